alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction issue and write-back stage feeding the 8-bit registered ALU. Accepts one 16-bit instruction per valid/ready handshake, reads operands from a 4-entry internal register file, drives the ALU's operand/control/enable inputs for one cycle, then captures the ALU result into the destination register and updates its own status flags. It sits directly upstream of the ALU and also consumes the ALU result, closing the execute loop of the simple CPU.

## Interface
- DATA_W, 8, operand/result width; must equal ALU width.
- ALU_LAT, 1, cycles from the ALU-sampling edge to a valid ALU result (1..4).

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr  in  16  instruction word (format below)
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_ctrl  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- alu_en  out  1  ALU enable, one-cycle pulse per ALU instruction
- alu_result  in  DATA_W  registered ALU output
- wb_valid  out  1  one-cycle pulse: register write occurred
- wb_rd  out  2  written register index
- wb_data  out  DATA_W  written value
- zero_flag, carry_flag, neg_flag  out  1  status of last ALU instruction

## Operation
- Format: instr[15:14] kind: 00 ALU, 01 LDI, 10/11 NOP. ALU: [13:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [5:0] ignored. LDI: [11:10] rd, [7:0] imm.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: instr_ready=1. On instr_valid&instr_ready: ALU -> latch op, rd, reg[rs1], reg[rs2]; go ISSUE. LDI -> go WB with imm as data. NOP -> stay IDLE, no side effects.
- ISSUE: alu_en=1, alu_a/alu_b/alu_ctrl = latched values; load latency counter with ALU_LAT-1; go WAIT if ALU_LAT>1 else WB.
- WAIT: decrement counter; at 0 go WB.
- WB: sample alu_result (ALU) or imm (LDI) into reg[rd]; wb_valid=1, wb_rd, wb_data = written value; go IDLE.
- Flags update only in WB of ALU instructions, computed internally from latched operands (not from ALU flag outputs): zero = (result==0) for all ops; carry = bit 8 of 9-bit a+b for add, else 0; neg = (a<b) unsigned for sub, else 0. LDI and NOP leave flags unchanged.
- alu_a/alu_b/alu_ctrl hold last issued values outside ISSUE; alu_en=0 outside ISSUE.
- Register-file reads use values as of the accept cycle; rd==rs1/rs2 is legal (old value read, new written).

## Timing
- Reset (async assert, sync-safe release): state IDLE, reg[0..3]=0, instr_ready=1, alu_en=0, alu_a=alu_b=0, alu_ctrl=00, wb_valid=0, wb_rd=0, wb_data=0, all flags 0.
- ALU instruction: accept edge T, alu_en high cycle T+1, ALU samples at end of T+1, write-back edge at end of T+1+ALU_LAT; next accept earliest one cycle after WB. Throughput with ALU_LAT=1: 1 instruction / 3 cycles.
- LDI: accept edge T, WB cycle T+1, instr_ready high again T+2.
- instr_ready is low in ISSUE, WAIT, WB; instr is ignored then.
- Reset asserted mid-instruction: aborts immediately, no write-back, alu_en drops asynchronously.

## Configuration
- ALU_ISSUE_DBG_EN defined: adds ports dbg_addr (in, 2) and dbg_data (out, DATA_W), combinational read of reg[dbg_addr], reflecting a WB write from the cycle after the write edge. Undefined: ports absent, no functional change otherwise.

## Test plan
- Reset then LDI r1=0x05, LDI r2=0x03 -> wb_valid pulses with (1,0x05), (2,0x03); flags stay 0.
- ADD r3=r1+r2 -> alu_en one cycle with a=0x05, b=0x03, ctrl=00; wb (3,0x08); zero=0 carry=0 neg=0.
- LDI r1=0xFF, LDI r2=0x01, ADD r0=r1+r2 -> wb (0,0x00); zero=1, carry=1.
- SUB r3=r2-r1 with r2=0x01, r1=0xFF -> wb (3,0x02); neg=1, carry=0; SUB r0=r1-r1 -> 0x00, zero=1, neg=0.
- instr_valid held high across back-to-back instructions, ALU_LAT=3 -> accepts only in IDLE, WB exactly 5 cycles after accept, NOP consumes one handshake with no wb_valid.
- Assert rst during WAIT of an ADD -> no wb_valid, all regs and outputs at reset values, next LDI completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/write-back stage wrapped around an external registered ALU.
// Latency: ALU op accept->write-back edge = 2+ALU_LAT cycles; LDI = 2 cycles; NOP = 1.
// Backpressure: instr_ready is high only in IDLE; instr is ignored while busy.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   instr_valid/instr_ready   16-bit instruction handshake (instr)
//   alu_a, alu_b, alu_ctrl    operands/op driven to the ALU, held between issues
//   alu_en                    one-cycle ALU enable pulse per ALU instruction
//   alu_result                registered ALU output, valid ALU_LAT edges after alu_en
//   wb_valid, wb_rd, wb_data  one-cycle register write-back report
//   zero/carry/neg_flag       status of the last completed ALU instruction
// Optional: define ALU_ISSUE_DBG_EN to add dbg_addr/dbg_data register-file read port.

module alu_issue_ctrl #(
   parameter int DATA_W  = 8,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_ctrl,
   output logic              alu_en,
   input  logic [DATA_W-1:0] alu_result,
   output logic              wb_valid,
   output logic [1:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic              neg_flag
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [1:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

   localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

   state_t            state_q;
   logic              ready_q;
   logic              alu_en_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [1:0]        alu_ctrl_q;
   logic [1:0]        rd_q;
   logic              is_alu_q;
   logic [DATA_W-1:0] imm_q;
   logic [1:0]        cnt_q;
   logic              wb_valid_q;
   logic [1:0]        wb_rd_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              zero_q, carry_q, neg_q;
   logic [DATA_W-1:0] rf_q [4];

   logic [DATA_W-1:0] wb_val_d;
   logic              carry_d;

   // Value written in WB: live ALU output for ALU ops, latched immediate for LDI.
   assign wb_val_d = is_alu_q ? alu_result : imm_q;
   // a+b overflows DATA_W bits exactly when a > (2^DATA_W-1-b), i.e. a > ~b.
   assign carry_d  = (alu_a_q > ~alu_b_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b1;
         alu_en_q   <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= 2'b00;
         rd_q       <= 2'd0;
         is_alu_q   <= 1'b0;
         imm_q      <= '0;
         cnt_q      <= 2'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 2'd0;
         wb_data_q  <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         neg_q      <= 1'b0;
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else begin
         alu_en_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (instr_valid) begin
                  case (instr[15:14])
                     2'b00: begin
                        // Operands read now, so rd==rs is safe: old value issued.
                        alu_ctrl_q <= instr[13:12];
                        rd_q       <= instr[11:10];
                        alu_a_q    <= rf_q[instr[9:8]];
                        alu_b_q    <= rf_q[instr[7:6]];
                        is_alu_q   <= 1'b1;
                        alu_en_q   <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= S_ISSUE;
                     end
                     2'b01: begin
                        rd_q       <= instr[11:10];
                        imm_q      <= DATA_W'(instr[7:0]);
                        is_alu_q   <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= instr[11:10];
                        ready_q    <= 1'b0;
                        state_q    <= S_WB;
                     end
                     default: ; // NOP: handshake consumed, nothing else happens
                  endcase
               end
            end
            S_ISSUE: begin
               cnt_q <= LAT_M1;
               if (ALU_LAT > 1) begin
                  state_q <= S_WAIT;
               end else begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  state_q    <= S_WB;
               end
            end
            S_WAIT: begin
               // Leave when the decremented count reaches zero: ALU_LAT-1 WAIT cycles.
               cnt_q <= cnt_q - 2'd1;
               if (cnt_q == 2'd1) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  state_q    <= S_WB;
               end
            end
            S_WB: begin
               rf_q[rd_q] <= wb_val_d;
               wb_data_q  <= wb_val_d;
               if (is_alu_q) begin
                  zero_q  <= (wb_val_d == '0);
                  carry_q <= (alu_ctrl_q == 2'b00) ? carry_d : 1'b0;
                  neg_q   <= (alu_ctrl_q == 2'b01) ? (alu_a_q < alu_b_q) : 1'b0;
               end
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign alu_en      = alu_en_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_ctrl    = alu_ctrl_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   // During WB the written value is presented live; otherwise the last written value holds.
   assign wb_data     = wb_valid_q ? wb_val_d : wb_data_q;
   assign zero_flag   = zero_q;
   assign carry_flag  = carry_q;
   assign neg_flag    = neg_q;

`ifdef ALU_ISSUE_DBG_EN
   assign dbg_data = rf_q[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a stand-in registered ALU.
// Latency: ALU stand-in returns results LAT edges after sampling alu_en.
// Backpressure: driver holds instr_valid until the DUT reports ready.

module tb_alu_issue_ctrl;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  alu_a, alu_b, alu_result;
   logic [1:0]  alu_ctrl;
   logic        alu_en;
   logic        wb_valid;
   logic [1:0]  wb_rd;
   logic [7:0]  wb_data;
   logic        zero_flag, carry_flag, neg_flag;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit started = 1'b0;

   alu_issue_ctrl #(.DATA_W(8), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
      .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Stand-in registered ALU with LAT-stage output pipeline.
   logic [7:0] alu_pipe [LAT];
   always @(posedge clk) begin
      if (alu_en) alu_pipe[0] <= alu_fn(alu_ctrl, alu_a, alu_b);
      for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
   end
   assign alu_result = alu_pipe[LAT-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model: cycle-scheduled transactions ----------------
   logic [7:0] m_reg [4];
   logic       m_z, m_c, m_n;
   logic [7:0] m_a, m_b;
   logic [1:0] m_ctrl;
   int         m_free, m_iss, m_wb;
   logic [1:0] m_wrd;
   logic [7:0] m_wval;
   logic       m_walu, m_wz, m_wc, m_wn;
   logic [7:0] t_a, t_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
         m_z = 0; m_c = 0; m_n = 0;
         m_a = 8'h00; m_b = 8'h00; m_ctrl = 2'b00;
         m_free = 0; m_iss = -1; m_wb = -1;
         m_wrd = 0; m_wval = 0; m_walu = 0; m_wz = 0; m_wc = 0; m_wn = 0;
      end else begin
         if (cyc == m_wb) begin
            m_reg[m_wrd] = m_wval;
            if (m_walu) begin m_z = m_wz; m_c = m_wc; m_n = m_wn; end
         end
         if (cyc >= m_free && instr_valid) begin
            case (instr[15:14])
               2'b00: begin
                  t_a = m_reg[instr[9:8]];
                  t_b = m_reg[instr[7:6]];
                  m_a = t_a; m_b = t_b; m_ctrl = instr[13:12];
                  m_wrd  = instr[11:10];
                  m_wval = alu_fn(instr[13:12], t_a, t_b);
                  m_walu = 1;
                  m_wz   = (m_wval == 8'h00);
                  m_wc   = (instr[13:12] == 2'b00) && ((int'(t_a) + int'(t_b)) > 255);
                  m_wn   = (instr[13:12] == 2'b01) && (t_a < t_b);
                  m_iss  = cyc + 1;
                  m_wb   = cyc + 1 + LAT;
                  m_free = cyc + 2 + LAT;
               end
               2'b01: begin
                  m_wrd  = instr[11:10];
                  m_wval = instr[7:0];
                  m_walu = 0;
                  m_wb   = cyc + 1;
                  m_free = cyc + 2;
               end
               default: m_free = cyc + 1;
            endcase
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (started && !rst) begin
         chk("instr_ready", 32'(instr_ready), 32'(cyc >= m_free));
         chk("alu_en",      32'(alu_en),      32'(cyc == m_iss));
         chk("alu_a",       32'(alu_a),       32'(m_a));
         chk("alu_b",       32'(alu_b),       32'(m_b));
         chk("alu_ctrl",    32'(alu_ctrl),    32'(m_ctrl));
         chk("wb_valid",    32'(wb_valid),    32'(cyc == m_wb));
         if (cyc == m_wb) begin
            chk("wb_rd",   32'(wb_rd),   32'(m_wrd));
            chk("wb_data", 32'(wb_data), 32'(m_wval));
         end
         chk("zero_flag",  32'(zero_flag),  32'(m_z));
         chk("carry_flag", 32'(carry_flag), 32'(m_c));
         chk("neg_flag",   32'(neg_flag),   32'(m_n));
      end
   end

   int wb_seen [4];
   always @(negedge clk) if (!rst && wb_valid) wb_seen[wb_rd] = cyc;

   // ---------------- directed driver with literal expectations ----------------
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [15:0] w, input bit hold, output int acc_c);
      int n;
      n = 0;
      instr = w;
      instr_valid = 1'b1;
      while (!instr_ready && n < 50) begin @(negedge clk); n++; end
      if (!instr_ready) begin
         fails++; tests++;
         $display("FAIL accept_timeout: instr 0x%0h not accepted within 50 cycles", w);
      end
      acc_c = cyc;
      @(negedge clk);
      if (!hold) begin instr_valid = 1'b0; instr = 16'h0000; end
   endtask

   task automatic expect_issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      int n;
      n = 0;
      while (!alu_en && n < 10) begin @(negedge clk); n++; end
      chk("issue_alu_en_seen", 32'(alu_en), 32'd1);
      chk("issue_a",    32'(alu_a),    32'(a));
      chk("issue_b",    32'(alu_b),    32'(b));
      chk("issue_ctrl", 32'(alu_ctrl), 32'(op));
   endtask

   task automatic expect_wb(input logic [1:0] rd, input logic [7:0] d, input bit z, input bit c, input bit ng);
      int n;
      n = 0;
      while (!wb_valid && n < 40) begin @(negedge clk); n++; end
      chk("wb_pulse_seen", 32'(wb_valid), 32'd1);
      chk("lit_wb_rd",   32'(wb_rd),   32'(rd));
      chk("lit_wb_data", 32'(wb_data), 32'(d));
      @(negedge clk);
      chk("wb_pulse_end", 32'(wb_valid), 32'd0);
      chk("lit_zero",  32'(zero_flag),  32'(z));
      chk("lit_carry", 32'(carry_flag), 32'(c));
      chk("lit_neg",   32'(neg_flag),   32'(ng));
   endtask

   task automatic check_reset_vals();
      chk("rst_instr_ready", 32'(instr_ready), 32'd1);
      chk("rst_alu_en",      32'(alu_en),      32'd0);
      chk("rst_alu_a",       32'(alu_a),       32'd0);
      chk("rst_alu_b",       32'(alu_b),       32'd0);
      chk("rst_alu_ctrl",    32'(alu_ctrl),    32'd0);
      chk("rst_wb_valid",    32'(wb_valid),    32'd0);
      chk("rst_wb_rd",       32'(wb_rd),       32'd0);
      chk("rst_wb_data",     32'(wb_data),     32'd0);
      chk("rst_zero",        32'(zero_flag),   32'd0);
      chk("rst_carry",       32'(carry_flag),  32'd0);
      chk("rst_neg",         32'(neg_flag),    32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, a3, acc;
      rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      started = 1'b1;
      @(negedge clk);

      send(16'h4405, 0, acc); expect_wb(2'd1, 8'h05, 0, 0, 0);        // LDI r1=05
      send(16'h4803, 0, acc); expect_wb(2'd2, 8'h03, 0, 0, 0);        // LDI r2=03
      send(16'h0D80, 0, acc); expect_issue(8'h05, 8'h03, 2'b00);     // ADD r3=r1+r2
      expect_wb(2'd3, 8'h08, 0, 0, 0);
      send(16'h44FF, 0, acc); expect_wb(2'd1, 8'hFF, 0, 0, 0);        // LDI r1=FF
      send(16'h4801, 0, acc); expect_wb(2'd2, 8'h01, 0, 0, 0);        // LDI r2=01
      send(16'h0180, 0, acc); expect_issue(8'hFF, 8'h01, 2'b00);     // ADD r0=r1+r2
      expect_wb(2'd0, 8'h00, 1, 1, 0);
      send(16'h1E40, 0, acc); expect_issue(8'h01, 8'hFF, 2'b01);     // SUB r3=r2-r1
      expect_wb(2'd3, 8'h02, 0, 0, 1);
      send(16'h1140, 0, acc); expect_wb(2'd0, 8'h00, 1, 0, 0);        // SUB r0=r1-r1
      send(16'h4C02, 0, acc); expect_wb(2'd3, 8'h02, 1, 0, 0);        // LDI keeps flags
      send(16'h29C0, 0, acc); expect_issue(8'hFF, 8'h02, 2'b10);     // AND r2=r1&r3
      expect_wb(2'd2, 8'h02, 0, 0, 0);

      // Back-to-back with instr_valid held high throughout.
      send(16'h4410, 1, a0);                                           // LDI r1=10
      send(16'h8000, 1, a1);                                           // NOP
      send(16'h0940, 1, a2);                                           // ADD r2=r1+r1
      send(16'h3E40, 0, a3);                                           // OR  r3=r2|r1
      expect_wb(2'd3, 8'h30, 0, 0, 0);
      chk("b2b_ldi_to_nop_accept", 32'(a1 - a0), 32'd2);
      chk("b2b_nop_to_add_accept", 32'(a2 - a1), 32'd1);
      chk("b2b_add_to_or_accept",  32'(a3 - a2), 32'd5);
      chk("b2b_add_wb_cycle",      32'(wb_seen[2] - a2), 32'd4);

      // Reset during WAIT of an ADD.
      send(16'h1140, 0, acc); expect_wb(2'd0, 8'h00, 1, 0, 0);        // zero=1 before reset
      send(16'h0D80, 0, acc);                                          // ISSUE cycle
      @(negedge clk);                                                  // WAIT cycle
      rst = 1'b1;
      #1;
      check_reset_vals();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_wb", 32'(wb_valid), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      send(16'h4407, 0, acc); expect_wb(2'd1, 8'h07, 0, 0, 0);        // LDI r1=07
      send(16'h09C0, 0, acc); expect_issue(8'h07, 8'h00, 2'b00);     // ADD r2=r1+r3 (r3 cleared)
      expect_wb(2'd2, 8'h07, 0, 0, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
